// File: rtl/dcache_sa.sv
// Set-associative write-back, write-allocate data cache with round-robin replacement and flush.
// Define DCACHE_STATS_EN to add the hit/miss/write-back counters.
module dcache_sa #(
    parameter int XLEN       = 32,
    parameter int ADDR_W     = 10,
    parameter int WAYS       = 2,
    parameter int SETS       = 4,
    parameter int LINE_WORDS = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    MEM_ld,
    input  logic                                    MEM_str,
    input  logic                                    MEM_byt,
    input  logic [XLEN-1:0]                         MEM_alu_out,
    input  logic [XLEN-1:0]                         MEM_b2,
    output logic [XLEN-1:0]                         MEM_data_mem,
    output logic                                    MEM_stall,
    input  logic                                    flush,
    output logic                                    flush_done,
    output logic                                    Dc_rd_req,
    output logic [ADDR_W-$clog2(LINE_WORDS)-1:0]    Dc_rd_addr,
    input  logic [LINE_WORDS*XLEN-1:0]              Dc_rline,
    input  logic                                    Dc_rd_valid,
    output logic                                    Dc_wb_req,
    output logic [ADDR_W-$clog2(LINE_WORDS)-1:0]    Dc_wb_addr,
    output logic [LINE_WORDS*XLEN-1:0]              Dc_wb_wline,
    input  logic                                    Dc_wb_ack
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]                             hit_cnt,
    output logic [31:0]                             miss_cnt,
    output logic [31:0]                             wb_cnt
`endif
);

    localparam int OFF_W   = $clog2(LINE_WORDS);
    localparam int IDX_W   = $clog2(SETS);
    localparam int TAG_W   = ADDR_W - IDX_W - OFF_W;
    localparam int LA_W    = ADDR_W - OFF_W;
    localparam int IDX_S   = (IDX_W > 0) ? IDX_W : 1;
    localparam int WAY_LOG = $clog2(WAYS);
    localparam int WAY_W   = (WAYS > 1) ? WAY_LOG : 1;
    localparam int NLINES  = SETS * WAYS;
    localparam int CNT_W   = (NLINES > 1) ? $clog2(NLINES) : 1;
    localparam int LINE_W  = LINE_WORDS * XLEN;

    typedef enum logic [2:0] {IDLE, WB, REFILL, FLUSH_SCAN, FLUSH_WB} state_t;

    state_t                       state_q, state_d;
    logic [SETS-1:0][WAYS-1:0]    valid_q, dirty_q;
    logic [WAY_W-1:0]             rr_ptr_q [SETS];
    logic [TAG_W-1:0]             tag_arr  [SETS][WAYS];
    logic [LINE_W-1:0]            data_arr [SETS][WAYS];

    logic [LA_W-1:0]              rd_addr_q, wb_addr_q;
    logic [LINE_W-1:0]            wb_wline_q;
    logic [WAY_W-1:0]             miss_way_q;
    logic [CNT_W-1:0]             fl_cnt_q;
    logic                         flush_done_q, flush_done_d;

    function automatic logic [XLEN-1:0] load_fmt(input logic [XLEN-1:0] w, input logic byt);
        load_fmt = byt ? {{(XLEN-8){1'b0}}, w[7:0]} : w;
    endfunction

    function automatic logic [XLEN-1:0] merge_store(input logic [XLEN-1:0] old_w,
                                                    input logic [XLEN-1:0] new_w,
                                                    input logic            byt);
        merge_store = byt ? {old_w[XLEN-1:8], new_w[7:0]} : new_w;
    endfunction

    function automatic logic [LA_W-1:0] mk_la(input logic [TAG_W-1:0] t, input logic [IDX_S-1:0] i);
        mk_la = (LA_W'(t) << IDX_W) | LA_W'(i);
    endfunction

    function automatic logic [WAY_W-1:0] rr_next(input logic [WAY_W-1:0] p);
        rr_next = WAY_W'((32'(p) + 1) % WAYS);
    endfunction

    logic [LA_W-1:0]   cur_la;
    logic [IDX_S-1:0]  cur_idx, miss_idx, fl_set;
    logic [TAG_W-1:0]  cur_tag, miss_tag;
    logic [OFF_W-1:0]  cur_off;
    logic [WAY_W-1:0]  hit_way, inv_way, vic_way, fl_way;
    logic              hit, has_inv, vic_dirty;
    logic [LINE_W-1:0] hit_line, st_line;
    logic [XLEN-1:0]   hit_word;
    logic              acc, idle, lk_hit, lk_miss, flush_go, fl_last, fl_dirty;

    assign cur_la   = MEM_alu_out[ADDR_W-1:OFF_W];
    assign cur_off  = MEM_alu_out[OFF_W-1:0];
    assign cur_idx  = IDX_S'(cur_la & LA_W'(SETS-1));
    assign cur_tag  = TAG_W'(cur_la >> IDX_W);
    assign miss_idx = IDX_S'(rd_addr_q & LA_W'(SETS-1));
    assign miss_tag = TAG_W'(rd_addr_q >> IDX_W);
    assign fl_set   = IDX_S'(fl_cnt_q >> WAY_LOG);
    assign fl_way   = WAY_W'(fl_cnt_q & CNT_W'(WAYS-1));
    assign fl_last  = (fl_cnt_q == CNT_W'(NLINES-1));
    assign fl_dirty = dirty_q[fl_set][fl_way];

    // Lowest hitting way wins; victim is the lowest invalid way, else the round-robin pointer.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        has_inv = 1'b0;
        inv_way = '0;
        for (int w = WAYS-1; w >= 0; w--) begin
            if (valid_q[cur_idx][WAY_W'(w)] && tag_arr[cur_idx][w] == cur_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[cur_idx][WAY_W'(w)]) begin
                has_inv = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
        vic_way   = has_inv ? inv_way : rr_ptr_q[cur_idx];
        vic_dirty = valid_q[cur_idx][vic_way] && dirty_q[cur_idx][vic_way];
        hit_line  = data_arr[cur_idx][hit_way];
        hit_word  = hit_line[cur_off*XLEN +: XLEN];
        st_line   = hit_line;
        st_line[cur_off*XLEN +: XLEN] = merge_store(hit_word, MEM_b2, MEM_byt);
    end

    assign acc      = MEM_ld | MEM_str;
    assign idle     = (state_q == IDLE);
    assign lk_hit   = idle && acc && hit;
    assign lk_miss  = idle && acc && !hit;
    assign flush_go = idle && flush && !acc;

    assign MEM_data_mem = (lk_hit && MEM_ld) ? load_fmt(hit_word, MEM_byt) : MEM_alu_out;
    assign Dc_rd_addr   = rd_addr_q;
    assign Dc_wb_addr   = wb_addr_q;
    assign Dc_wb_wline  = wb_wline_q;
    assign flush_done   = flush_done_q;

    always_comb begin
        state_d      = state_q;
        MEM_stall    = 1'b1;
        Dc_rd_req    = 1'b0;
        Dc_wb_req    = 1'b0;
        flush_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                MEM_stall = lk_miss;
                if (lk_miss)       state_d = vic_dirty ? WB : REFILL;
                else if (flush_go) state_d = FLUSH_SCAN;
            end
            WB: begin
                Dc_wb_req = 1'b1;
                if (Dc_wb_ack) state_d = REFILL;
            end
            REFILL: begin
                Dc_rd_req = 1'b1;
                if (Dc_rd_valid) state_d = IDLE;
            end
            FLUSH_SCAN: begin
                if (fl_dirty) begin
                    state_d = FLUSH_WB;
                end else if (fl_last) begin
                    state_d      = IDLE;
                    flush_done_d = 1'b1;
                end
            end
            FLUSH_WB: begin
                Dc_wb_req = 1'b1;
                if (Dc_wb_ack) begin
                    state_d      = fl_last ? IDLE : FLUSH_SCAN;
                    flush_done_d = fl_last;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            for (int s = 0; s < SETS; s++) rr_ptr_q[s] <= '0;
            rd_addr_q    <= '0;
            wb_addr_q    <= '0;
            wb_wline_q   <= '0;
            miss_way_q   <= '0;
            fl_cnt_q     <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_done_q <= flush_done_d;
            case (state_q)
                IDLE: begin
                    if (lk_hit && MEM_str) dirty_q[cur_idx][hit_way] <= 1'b1;
                    if (lk_miss) begin
                        rd_addr_q  <= cur_la;
                        miss_way_q <= vic_way;
                        if (vic_dirty) begin
                            wb_addr_q  <= mk_la(tag_arr[cur_idx][vic_way], cur_idx);
                            wb_wline_q <= data_arr[cur_idx][vic_way];
                        end
                    end
                    if (flush_go) fl_cnt_q <= '0;
                end
                WB: if (Dc_wb_ack) dirty_q[miss_idx][miss_way_q] <= 1'b0;
                REFILL: begin
                    if (Dc_rd_valid) begin
                        valid_q[miss_idx][miss_way_q] <= 1'b1;
                        dirty_q[miss_idx][miss_way_q] <= 1'b0;
                        rr_ptr_q[miss_idx]            <= rr_next(rr_ptr_q[miss_idx]);
                    end
                end
                FLUSH_SCAN: begin
                    if (fl_dirty) begin
                        wb_addr_q  <= mk_la(tag_arr[fl_set][fl_way], fl_set);
                        wb_wline_q <= data_arr[fl_set][fl_way];
                    end else if (!fl_last) begin
                        fl_cnt_q <= fl_cnt_q + CNT_W'(1);
                    end
                end
                FLUSH_WB: begin
                    if (Dc_wb_ack) begin
                        dirty_q[fl_set][fl_way] <= 1'b0;
                        if (!fl_last) fl_cnt_q <= fl_cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays carry no reset; valid bits gate every use of them.
    always_ff @(posedge clk) begin
        if (lk_hit && MEM_str) data_arr[cur_idx][hit_way] <= st_line;
        if (state_q == REFILL && Dc_rd_valid) begin
            tag_arr[miss_idx][miss_way_q]  <= miss_tag;
            data_arr[miss_idx][miss_way_q] <= Dc_rline;
        end
    end

`ifdef DCACHE_STATS_EN
    logic relook_q;

    // The first IDLE cycle after a refill repeats the lookup and must not count as a hit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            relook_q <= 1'b0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
            wb_cnt   <= '0;
        end else begin
            relook_q <= (state_q == REFILL) && Dc_rd_valid;
            if (lk_hit && !relook_q) hit_cnt <= hit_cnt + 32'd1;
            if (lk_miss)             miss_cnt <= miss_cnt + 32'd1;
            if ((state_q == WB || state_q == FLUSH_WB) && Dc_wb_ack) wb_cnt <= wb_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_sa.sv
// Scoreboard bench for dcache_sa: directed loads/stores/flush/reset against a small backing memory.
`timescale 1ns/1ps
module tb_dcache_sa;

    localparam int XLEN = 32;
    localparam int LW   = 4;
    localparam int LA_W = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               MEM_ld = 1'b0, MEM_str = 1'b0, MEM_byt = 1'b0;
    logic [XLEN-1:0]    MEM_alu_out = 32'h123, MEM_b2 = '0;
    logic [XLEN-1:0]    MEM_data_mem;
    logic               MEM_stall;
    logic               flush = 1'b0;
    logic               flush_done;
    logic               Dc_rd_req, Dc_rd_valid, Dc_wb_req, Dc_wb_ack;
    logic [LA_W-1:0]    Dc_rd_addr, Dc_wb_addr;
    logic [LW*XLEN-1:0] Dc_rline, Dc_wb_wline;
`ifdef DCACHE_STATS_EN
    logic [31:0]        hit_cnt, miss_cnt, wb_cnt;
`endif

    dcache_sa dut (
        .clk(clk), .rst(rst),
        .MEM_ld(MEM_ld), .MEM_str(MEM_str), .MEM_byt(MEM_byt),
        .MEM_alu_out(MEM_alu_out), .MEM_b2(MEM_b2),
        .MEM_data_mem(MEM_data_mem), .MEM_stall(MEM_stall),
        .flush(flush), .flush_done(flush_done),
        .Dc_rd_req(Dc_rd_req), .Dc_rd_addr(Dc_rd_addr), .Dc_rline(Dc_rline), .Dc_rd_valid(Dc_rd_valid),
        .Dc_wb_req(Dc_wb_req), .Dc_wb_addr(Dc_wb_addr), .Dc_wb_wline(Dc_wb_wline), .Dc_wb_ack(Dc_wb_ack)
`ifdef DCACHE_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rd_delay = 1, wb_delay = 1;
    int rd_wait = 0, wb_wait = 0;
    int rd_seen = 0, wb_seen = 0;
    logic [31:0] mem [256][LW];

    logic [31:0]     q_load[$];
    logic [LA_W-1:0] q_rd[$];
    logic [LA_W-1:0] q_wb_addr[$];
    logic [31:0]     q_wb_w0[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got 0x%08h with nothing expected", name, act);
    endtask

    // Backing memory: answers line reads and write-backs after programmable delays.
    initial begin
        Dc_rd_valid = 1'b0;
        Dc_wb_ack   = 1'b0;
        Dc_rline    = '0;
        forever begin
            @(posedge clk); #1;
            Dc_rd_valid = 1'b0;
            Dc_wb_ack   = 1'b0;
            if (Dc_wb_req) begin
                wb_wait++;
                if (wb_wait >= wb_delay) begin
                    for (int w = 0; w < LW; w++) mem[Dc_wb_addr][w] = Dc_wb_wline[w*XLEN +: XLEN];
                    Dc_wb_ack = 1'b1;
                    wb_wait   = 0;
                end
            end else begin
                wb_wait = 0;
            end
            if (Dc_rd_req) begin
                rd_wait++;
                if (rd_wait >= rd_delay) begin
                    for (int w = 0; w < LW; w++) Dc_rline[w*XLEN +: XLEN] = mem[Dc_rd_addr][w];
                    Dc_rd_valid = 1'b1;
                    rd_wait     = 0;
                end
            end else begin
                rd_wait = 0;
            end
        end
    end

    // Monitor: pops the expected response whenever the DUT presents one.
    always @(negedge clk) begin
        if (rst) begin
            if (MEM_ld && !MEM_stall) begin
                if (q_load.size() == 0) fail("unexpected_load", MEM_data_mem);
                else chk("load_data", MEM_data_mem, q_load.pop_front());
            end
            if (Dc_rd_req && Dc_rd_valid) begin
                rd_seen++;
                if (q_rd.size() == 0) fail("unexpected_refill", 32'(Dc_rd_addr));
                else chk("rd_addr", 32'(Dc_rd_addr), 32'(q_rd.pop_front()));
            end
            if (Dc_wb_req && Dc_wb_ack) begin
                wb_seen++;
                if (q_wb_addr.size() == 0) fail("unexpected_wb", 32'(Dc_wb_addr));
                else begin
                    chk("wb_addr", 32'(Dc_wb_addr), 32'(q_wb_addr.pop_front()));
                    chk("wb_word0", Dc_wb_wline[XLEN-1:0], q_wb_w0.pop_front());
                end
            end
        end
    end

    task automatic op(input logic ld, input logic st, input logic byt,
                      input logic [31:0] a, input logic [31:0] d, output int stalls);
        @(posedge clk); #1;
        MEM_ld = ld; MEM_str = st; MEM_byt = byt; MEM_alu_out = a; MEM_b2 = d;
        stalls = 0;
        @(negedge clk);
        while (MEM_stall && stalls < 200) begin
            stalls++;
            @(negedge clk);
        end
        if (MEM_stall) fail("op_timeout", a);
        @(posedge clk); #1;
        MEM_ld = 1'b0; MEM_str = 1'b0; MEM_byt = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic byt, input logic [31:0] exp, input int exp_stalls);
        int st;
        q_load.push_back(exp);
        op(1'b1, 1'b0, byt, a, 32'h0, st);
        chk($sformatf("load_stalls_%03h", a), st, exp_stalls);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic byt, input int exp_stalls);
        int st;
        op(1'b0, 1'b1, byt, a, d, st);
        chk($sformatf("store_stalls_%03h", a), st, exp_stalls);
    endtask

    task automatic do_flush(input int exp_wbs);
        int cyc, nostall, wb0;
        wb0 = wb_seen;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        cyc = 0;
        nostall = 0;
        @(negedge clk);
        while (!flush_done && cyc < 300) begin
            if (!MEM_stall) nostall++;
            cyc++;
            @(negedge clk);
        end
        chk("flush_done_seen", flush_done, 1'b1);
        chk("flush_stall_held", nostall, 0);
        chk("flush_wb_count", wb_seen - wb0, exp_wbs);
        @(negedge clk);
        chk("flush_done_pulse", flush_done, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int la = 0; la < 256; la++)
            for (int w = 0; w < LW; w++) mem[la][w] = 32'hC000_0000 + 32'(la * 16 + w);
        for (int w = 0; w < LW; w++) mem[5][w] = 32'hA0 + 32'(w);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rd_req", Dc_rd_req, 1'b0);
        rst = 1'b1;
        #1;
        chk("reset_wb_req", Dc_wb_req, 1'b0);
        chk("reset_stall", MEM_stall, 1'b0);
        chk("reset_flush_done", flush_done, 1'b0);
        chk("reset_rd_addr", 32'(Dc_rd_addr), 32'h0);
        chk("reset_wb_addr", 32'(Dc_wb_addr), 32'h0);
        chk("reset_wb_wline", Dc_wb_wline[31:0] | Dc_wb_wline[127:96], 32'h0);
        chk("passthrough_idle", MEM_data_mem, 32'h123);

        // Cold miss with a 3-cycle refill, then a zero-latency hit in the same line.
        rd_delay = 3;
        q_rd.push_back(8'h05);
        load(32'h014, 1'b0, 32'hA0, 4);
        load(32'h017, 1'b0, 32'hA3, 0);

        rd_delay = 1;
        store(32'h015, 32'hDEADBEEF, 1'b0, 0);
        load(32'h015, 1'b0, 32'hDEADBEEF, 0);

        store(32'h016, 32'h11223344, 1'b0, 0);
        store(32'h016, 32'hFFFFFF5A, 1'b1, 0);
        load(32'h016, 1'b0, 32'h1122335A, 0);
        load(32'h016, 1'b1, 32'h0000005A, 0);

        // Set 0 conflict: dirty victim written back before the refill.
        q_rd.push_back(8'h00);
        load(32'h000, 1'b0, 32'hC000_0000, 2);
        q_rd.push_back(8'h04);
        load(32'h010, 1'b0, 32'hC000_0040, 2);
        store(32'h000, 32'h77, 1'b0, 0);
        wb_delay = 4;
        q_wb_addr.push_back(8'h00); q_wb_w0.push_back(32'h77);
        q_rd.push_back(8'h08);
        load(32'h020, 1'b0, 32'hC000_0080, 6);
        chk("mem_wb_word0", mem[0][0], 32'h77);
        chk("mem_wb_word1", mem[0][1], 32'hC000_0001);
        q_rd.push_back(8'h0C);
        load(32'h030, 1'b0, 32'hC000_00C0, 2);

        // Flush with two dirty lines, in set-major order, then an idle flush.
        store(32'h030, 32'h33333333, 1'b0, 0);
        wb_delay = 2;
        q_wb_addr.push_back(8'h0C); q_wb_w0.push_back(32'h33333333);
        q_wb_addr.push_back(8'h05); q_wb_w0.push_back(32'hA0);
        do_flush(2);
        chk("mem_flush_line5_w1", mem[5][1], 32'hDEADBEEF);
        load(32'h014, 1'b0, 32'hA0, 0);
        load(32'h030, 1'b0, 32'h33333333, 0);
        do_flush(0);

        // Reset in the middle of a refill.
        rd_delay = 50;
        @(posedge clk); #1;
        MEM_ld = 1'b1; MEM_alu_out = 32'h040;
        repeat (3) @(negedge clk);
        chk("refill_rd_req", Dc_rd_req, 1'b1);
        chk("refill_rd_addr", 32'(Dc_rd_addr), 32'h10);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rd_req", Dc_rd_req, 1'b0);
        chk("async_rd_addr", 32'(Dc_rd_addr), 32'h0);
        chk("miss_passthrough", MEM_data_mem, 32'h040);
        MEM_ld = 1'b0;
        #1;
        chk("async_idle", MEM_stall, 1'b0);
        @(negedge clk); #1;
        rst = 1'b1;
        rd_delay = 1;
        q_rd.push_back(8'h05);
        load(32'h014, 1'b0, 32'hA0, 2);
        load(32'h015, 1'b0, 32'hDEADBEEF, 0);

        repeat (4) @(posedge clk);
        chk("load_queue_drained", q_load.size(), 0);
        chk("rd_queue_drained", q_rd.size(), 0);
        chk("wb_queue_drained", q_wb_addr.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
